tl_broadcast_d_responder: RTL and testbench
===========================================

Name: tl_broadcast_d_responder

Overview:
- Response-side companion to the broadcast A-channel tracker; one instance per tracker slot.
- Counts outstanding probe acks, takes the outer (memory-side) D responses and returns them to the inner client on D.
- Converts AccessAck/AccessAckData to Grant/GrantData for Acquires, counts beats and pulses d_last.
- Closes the transaction when the client's GrantAck (E) arrives, driving the tracker's got_e/sent_d bookkeeping.

Parameters:
- SOURCE_W, 8, inner source id width; outer source is SOURCE_W+2 (top 2 bits = acquire tag).
- SINK_ID, 0, 3-bit sink id placed on Grant and matched against E.
- BEAT_LOG2, 3, log2 bytes per D beat (64-bit data).
- PROBE_W, 3, probe counter width.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start_valid  in  1  tracker accepted a first A beat; loads context
- start_opcode, start_param, start_size  in  3 each  captured A fields
- start_source  in  SOURCE_W  captured A source
- start_probes  in  PROBE_W  number of probes issued for this line (0 allowed)
- probe_ack  in  1  one-cycle pulse per ProbeAck received
- od_ready  out  1, od_valid  in  1  outer D handshake
- od_opcode  in  3, od_size  in  3, od_source  in  SOURCE_W+2, od_denied  in  1, od_data  in  64
- id_ready  in  1, id_valid  out  1  inner D handshake
- id_opcode, id_param, id_size  out  3 each; id_sink  out  3; id_source  out  SOURCE_W; id_denied  out  1; id_data  out  64
- e_valid  in  1, e_sink  in  3  inner E (GrantAck); always accepted
- d_last  out  1  pulse on final inner D beat fire
- got_e  out  1  high when no E outstanding
- probes_done  out  1  probe count is zero
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset values: state IDLE, counters 0, got_e=1, probes_done=1, busy=0, d_last=0, id_valid=0, od_ready=0, err=0.
- acquire = captured opcode 6 or 7.
- States: IDLE -> PROBE on start_valid; PROBE -> RESP when count==0 (same cycle as load if start_probes==0, i.e. PROBE lasts exactly one cycle); RESP -> WAIT_E on last beat fire if acquire, else -> IDLE; WAIT_E -> IDLE on e_valid with e_sink==SINK_ID.
- start_valid outside IDLE is ignored (err in check mode); in IDLE it captures all start fields and clears got_e if acquire.
- Probe count: load start_probes; decrement on probe_ack; probe_ack at zero saturates (no wrap).
- D pass-through: combinational, zero latency; od_ready = id_ready & (state==RESP); id_valid = od_valid & (state==RESP). No buffering.
- Opcode map when acquire: 1->5 (GrantData), 0->4 (Grant); otherwise opcode passes unchanged.
- Param when acquire: captured param 0 (NtoB) -> 1 (toB); 1 or 2 -> 0 (toT). Non-acquire: 0.
- id_size = od_size; id_source = od_source[SOURCE_W-1:0]; id_sink = SINK_ID; data/denied pass through.
- Beats: data-bearing opcode (1) -> max(1, 2^od_size >> BEAT_LOG2) beats, else 1. Beat counter increments per fire; last beat is count==beats-1, and the counter returns to 0 on it.
- d_last: registered one-cycle pulse the cycle after the last fire.
- got_e set on matching E; E with mismatched sink or outside WAIT_E ignored.
- Reset mid-operation returns to IDLE immediately; in-flight beats are dropped.

Optional Feature:
- Macro TL_BCAST_RESP_CHECK_EN.
- Defined: err sets (sticky until reset) on
  - od_source[SOURCE_W-1:0] != captured source during a fire;
  - start_valid while busy;
  - probe_ack at count 0;
  - od tag bits != {2{acquire}}.
- Not defined: err tied 0, no check logic.

Decomposition:
- Package tl_bcast_pkg: opcode constants (AccessAck 0, AccessAckData 1, Grant 4, GrantData 5, AcquireBlock 6, AcquirePerm 7), cap constants (toT 0, toB 1), state enum.
- Optional sub-module tl_beat_counter (size+opcode -> beats, first/last).
- FSM and mapping stay in the top.

Test Plan:
- Get, no probes: start(op4,size6,src 0x12,probes 0); 8 beats of opcode 1 -> 8 id fires of opcode 1, src 0x12; d_last one cycle after 8th fire; busy falls, got_e stays 1.
- AcquireBlock NtoT with 2 probes: od_valid held high; od_ready stays 0 until the 2nd probe_ack. Then 8 beats out as GrantData param 0 sink SINK_ID; state WAIT_E until E sink matches; got_e 0 -> 1.
- Acquire NtoB, AccessAck size 6: single beat out as Grant (4), param 1; d_last after 1 fire.
- Backpressure: id_ready toggles every other cycle during a 4-beat response (size 5). Exactly 4 fires, no od beat lost; d_last once.
- E with wrong sink during WAIT_E: no transition. Correct sink next cycle -> IDLE.
- Reset asserted mid-RESP after 3 of 8 beats: outputs return to reset values asynchronously. With TL_BCAST_RESP_CHECK_EN, a source mismatch sets err, which holds until reset.

Source files
------------

// File: rtl/tl_bcast_pkg.sv
// Shared constants and types for the broadcast D-channel responder.
// Holds TileLink opcode/cap encodings, the responder state enum and a
// small helper that recognises Acquire requests.
package tl_bcast_pkg;

  // D-channel and A-channel opcodes used by the responder
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] OP_GRANT           = 3'd4;
  localparam logic [2:0] OP_GRANT_DATA      = 3'd5;
  localparam logic [2:0] OP_ACQUIRE_BLOCK   = 3'd6;
  localparam logic [2:0] OP_ACQUIRE_PERM    = 3'd7;

  // Grow params on A (NtoB) and cap params on D (toT/toB)
  localparam logic [2:0] GROW_NTOB = 3'd0;
  localparam logic [2:0] CAP_TOT   = 3'd0;
  localparam logic [2:0] CAP_TOB   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PROBE  = 2'd1,
    ST_RESP   = 2'd2,
    ST_WAIT_E = 2'd3
  } state_t;

  function automatic logic is_acquire(input logic [2:0] op);
    return (op == OP_ACQUIRE_BLOCK) || (op == OP_ACQUIRE_PERM);
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat counter for one D response burst.
// Derives the burst length from the live D opcode/size and flags the
// final beat; the count wraps to zero on the last fire so the next burst
// starts clean.
module tl_beat_counter
  import tl_bcast_pkg::*;
#(
  parameter int BEAT_LOG2 = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       fire,
  input  logic [2:0] opcode,
  input  logic [2:0] size,
  output logic       last
);

  logic [8:0] r_cnt;
  logic [8:0] w_bytes;
  logic [8:0] w_shift;
  logic [8:0] w_beats;

  assign w_bytes = 9'd1 << size;
  assign w_shift = w_bytes >> BEAT_LOG2;
  // Only AccessAckData carries data; anything narrower than a beat is one beat
  assign w_beats = ((opcode == OP_ACCESS_ACK_DATA) && (w_shift != 9'd0)) ? w_shift : 9'd1;
  assign last    = (r_cnt == (w_beats - 9'd1));

  // Advance per fire, return to zero on the last beat or when idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= 9'd0;
    end else if (clear) begin
      r_cnt <= 9'd0;
    end else if (fire) begin
      r_cnt <= last ? 9'd0 : (r_cnt + 9'd1);
    end
  end

endmodule

// File: rtl/tl_broadcast_d_responder.sv
// Response side of one broadcast tracker slot.
// Waits out probe acks, passes outer D beats to the inner client with
// Acquire responses rewritten as Grant/GrantData, then waits for GrantAck.
// Optional protocol checking is enabled with macro TL_BCAST_RESP_CHECK_EN.
module tl_broadcast_d_responder
  import tl_bcast_pkg::*;
#(
  parameter int         SOURCE_W  = 8,
  parameter logic [2:0] SINK_ID   = 3'd0,
  parameter int         BEAT_LOG2 = 3,
  parameter int         PROBE_W   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_valid,
  input  logic [2:0]            start_opcode,
  input  logic [2:0]            start_param,
  input  logic [2:0]            start_size,
  input  logic [SOURCE_W-1:0]   start_source,
  input  logic [PROBE_W-1:0]    start_probes,
  input  logic                  probe_ack,
  output logic                  od_ready,
  input  logic                  od_valid,
  input  logic [2:0]            od_opcode,
  input  logic [2:0]            od_size,
  input  logic [SOURCE_W+1:0]   od_source,
  input  logic                  od_denied,
  input  logic [63:0]           od_data,
  input  logic                  id_ready,
  output logic                  id_valid,
  output logic [2:0]            id_opcode,
  output logic [2:0]            id_param,
  output logic [2:0]            id_size,
  output logic [2:0]            id_sink,
  output logic [SOURCE_W-1:0]   id_source,
  output logic                  id_denied,
  output logic [63:0]           id_data,
  input  logic                  e_valid,
  input  logic [2:0]            e_sink,
  output logic                  d_last,
  output logic                  got_e,
  output logic                  probes_done,
  output logic                  busy,
  output logic                  err
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_acquire;
  logic [2:0]           r_param;
  logic [PROBE_W-1:0]   r_probe_cnt;
  logic                 r_got_e;
  logic                 r_d_last;
  logic                 w_in_resp;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_e_match;
  logic                 w_start;

  assign w_in_resp = (r_state == ST_RESP);
  assign w_fire    = od_valid & id_ready & w_in_resp;
  assign w_e_match = (r_state == ST_WAIT_E) & e_valid & (e_sink == SINK_ID);
  assign w_start   = (r_state == ST_IDLE) & start_valid;

  tl_beat_counter #(
    .BEAT_LOG2 (BEAT_LOG2)
  ) u_beats (
    .clock  (clock),
    .reset  (reset),
    .clear  (r_state == ST_IDLE),
    .fire   (w_fire),
    .opcode (od_opcode),
    .size   (od_size),
    .last   (w_last)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: probes drain, burst completes, then GrantAck for Acquires
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_valid) w_state_next = ST_PROBE;
      ST_PROBE:  if (r_probe_cnt == '0) w_state_next = ST_RESP;
      ST_RESP:   if (w_fire && w_last) w_state_next = r_acquire ? ST_WAIT_E : ST_IDLE;
      ST_WAIT_E: if (w_e_match) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Transaction context, probe count, GrantAck bookkeeping and d_last pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acquire   <= 1'b0;
      r_param     <= 3'd0;
      r_probe_cnt <= '0;
      r_got_e     <= 1'b1;
      r_d_last    <= 1'b0;
    end else begin
      r_d_last <= w_fire & w_last;
      if (w_start) begin
        r_acquire   <= is_acquire(start_opcode);
        r_param     <= start_param;
        r_probe_cnt <= start_probes;
        r_got_e     <= ~is_acquire(start_opcode);
      end else begin
        // A stray ack at zero saturates instead of wrapping
        if (probe_ack && (r_probe_cnt != '0)) begin
          r_probe_cnt <= r_probe_cnt - 1'b1;
        end
        if (w_e_match) begin
          r_got_e <= 1'b1;
        end
      end
    end
  end

  // Opcode/param rewrite: Acquires see Grant flavours and a cap param
  always_comb begin
    id_opcode = od_opcode;
    id_param  = CAP_TOT;
    if (r_acquire) begin
      if (od_opcode == OP_ACCESS_ACK_DATA) begin
        id_opcode = OP_GRANT_DATA;
      end else if (od_opcode == OP_ACCESS_ACK) begin
        id_opcode = OP_GRANT;
      end
      id_param = (r_param == GROW_NTOB) ? CAP_TOB : CAP_TOT;
    end
  end

  assign od_ready    = id_ready & w_in_resp;
  assign id_valid    = od_valid & w_in_resp;
  assign id_size     = od_size;
  assign id_source   = od_source[SOURCE_W-1:0];
  assign id_sink     = SINK_ID;
  assign id_denied   = od_denied;
  assign id_data     = od_data;
  assign d_last      = r_d_last;
  assign got_e       = r_got_e;
  assign probes_done = (r_probe_cnt == '0);
  assign busy        = (r_state != ST_IDLE);

`ifdef TL_BCAST_RESP_CHECK_EN
  logic [SOURCE_W-1:0] r_source;
  logic                r_err;
  logic                w_err_evt;
  logic                w_unused;

  // The captured A size is carried by od_size on the response itself
  assign w_unused = &{1'b0, start_size};

  assign w_err_evt = (w_fire && ((od_source[SOURCE_W-1:0] != r_source) ||
                                 (od_source[SOURCE_W+1:SOURCE_W] != {2{r_acquire}}))) ||
                     (start_valid && (r_state != ST_IDLE)) ||
                     (probe_ack && (r_probe_cnt == '0));

  // Source capture for the response-source check
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_source <= '0;
    end else if (w_start) begin
      r_source <= start_source;
    end
  end

  // Sticky protocol error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused;

  // Fields only consumed by the protocol checker
  assign w_unused = &{1'b0, start_size, start_source, od_source[SOURCE_W+1:SOURCE_W]};
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_tl_broadcast_d_responder.sv
// Directed bench for tl_broadcast_d_responder: Get, Acquire with probes,
// Grant without data, backpressure, GrantAck sink matching, mid-burst reset
// and the optional error flag (TL_BCAST_RESP_CHECK_EN).
module tb_tl_broadcast_d_responder;

  localparam int         SW   = 8;
  localparam logic [2:0] SINK = 3'd5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_valid = 1'b0;
  logic [2:0]    start_opcode = 3'd0, start_param = 3'd0, start_size = 3'd0;
  logic [SW-1:0] start_source = '0;
  logic [2:0]    start_probes = 3'd0;
  logic          probe_ack = 1'b0;
  logic          od_ready;
  logic          od_valid = 1'b0;
  logic [2:0]    od_opcode = 3'd0, od_size = 3'd0;
  logic [SW+1:0] od_source = '0;
  logic          od_denied = 1'b0;
  logic [63:0]   od_data = '0;
  logic          id_ready = 1'b0;
  logic          id_valid;
  logic [2:0]    id_opcode, id_param, id_size, id_sink;
  logic [SW-1:0] id_source;
  logic          id_denied;
  logic [63:0]   id_data;
  logic          e_valid = 1'b0;
  logic [2:0]    e_sink = 3'd0;
  logic          d_last, got_e, probes_done, busy, err;

  int n_checks = 0;
  int n_pass   = 0;

  tl_broadcast_d_responder #(
    .SOURCE_W (SW), .SINK_ID (SINK), .BEAT_LOG2 (3), .PROBE_W (3)
  ) dut (
    .clock (clock), .reset (reset),
    .start_valid (start_valid), .start_opcode (start_opcode), .start_param (start_param),
    .start_size (start_size), .start_source (start_source), .start_probes (start_probes),
    .probe_ack (probe_ack),
    .od_ready (od_ready), .od_valid (od_valid), .od_opcode (od_opcode), .od_size (od_size),
    .od_source (od_source), .od_denied (od_denied), .od_data (od_data),
    .id_ready (id_ready), .id_valid (id_valid), .id_opcode (id_opcode), .id_param (id_param),
    .id_size (id_size), .id_sink (id_sink), .id_source (id_source), .id_denied (id_denied),
    .id_data (id_data),
    .e_valid (e_valid), .e_sink (e_sink),
    .d_last (d_last), .got_e (got_e), .probes_done (probes_done), .busy (busy), .err (err)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                          input logic [SW-1:0] src, input logic [2:0] probes);
    start_opcode = op; start_param = prm; start_size = sz;
    start_source = src; start_probes = probes; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  // Drive a held od burst, count inner fires and check every fired beat,
  // then check the single d_last pulse
  task automatic run_beats(input string name, input int n, input logic [2:0] exp_op,
                           input logic [2:0] exp_param, input logic [SW-1:0] exp_src,
                           input bit toggle);
    int fires = 0;
    int early_dl = 0;
    int cyc = 0;
    int bad = 0;
    while (fires < n && cyc < 60) begin
      id_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      od_data  = 64'hA000 + 64'(fires);
      #1;
      if (d_last) early_dl++;
      if (id_valid && id_ready) begin
        if (id_opcode !== exp_op || id_param !== exp_param || id_source !== exp_src ||
            id_sink !== SINK || id_size !== od_size || id_data !== 64'hA000 + 64'(fires) ||
            od_ready !== 1'b1)
          bad++;
        fires++;
      end
      step();
      cyc++;
    end
    od_valid = 1'b0;
    id_ready = 1'b0;
    n_checks++;
    if (fires !== n) $display("FAIL %s fires: got %0d want %0d", name, fires, n);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL %s beat fields: %0d bad beats, want 0", name, bad);
    else n_pass++;
    n_checks++;
    if (d_last !== 1'b1 || early_dl !== 0)
      $display("FAIL %s d_last: got %b early %0d want 1 early 0", name, d_last, early_dl);
    else n_pass++;
    $display("txn %s: %0d beats in %0d cycles", name, fires, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({busy, got_e, probes_done, d_last, id_valid, od_ready, err} !== 7'b0110000)
      $display("FAIL reset_state: got %b want 0110000",
               {busy, got_e, probes_done, d_last, id_valid, od_ready, err});
    else n_pass++;
    reset = 1'b1;
    step();
    $display("txn reset released");
  endtask

  task automatic test_get();
    do_start(3'd4, 3'd0, 3'd6, 8'h12, 3'd0);
    od_valid = 1'b1; od_opcode = 3'd1; od_size = 3'd6; od_source = {2'b00, 8'h12};
    run_beats("get", 8, 3'd1, 3'd0, 8'h12, 1'b0);
    n_checks++;
    if (busy !== 1'b0 || got_e !== 1'b1)
      $display("FAIL get_done: busy %b got_e %b want 0 1", busy, got_e);
    else n_pass++;
    step();
    n_checks++;
    if (d_last !== 1'b0) $display("FAIL get_dlast_pulse: got %b want 0", d_last);
    else n_pass++;
  endtask

  task automatic test_acquire_probes();
    int early = 0;
    do_start(3'd6, 3'd1, 3'd6, 8'h34, 3'd2);
    od_valid = 1'b1; od_opcode = 3'd1; od_size = 3'd6; od_source = {2'b11, 8'h34};
    id_ready = 1'b1;
    n_checks++;
    if (got_e !== 1'b0 || probes_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL acq_start: got_e %b probes_done %b busy %b want 0 0 1", got_e, probes_done, busy);
    else n_pass++;
    repeat (3) begin #1; if (od_ready) early++; step(); end
    probe_ack = 1'b1; #1; if (od_ready) early++; step();
    probe_ack = 1'b0; #1; if (od_ready) early++; step();
    probe_ack = 1'b1; #1; if (od_ready) early++; step();
    probe_ack = 1'b0; #1; if (od_ready) early++;
    n_checks++;
    if (early !== 0) $display("FAIL acq_hold: od_ready high %0d cycles before probes done, want 0", early);
    else n_pass++;
    n_checks++;
    if (probes_done !== 1'b1) $display("FAIL acq_probes_done: got %b want 1", probes_done);
    else n_pass++;
    run_beats("acquire_block", 8, 3'd5, 3'd0, 8'h34, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || got_e !== 1'b0)
      $display("FAIL acq_wait_e: busy %b got_e %b want 1 0", busy, got_e);
    else n_pass++;
    // start while busy is ignored
    do_start(3'd4, 3'd0, 3'd0, 8'h01, 3'd0);
    e_valid = 1'b1; e_sink = SINK ^ 3'd1;
    step();
    n_checks++;
    if (busy !== 1'b1 || got_e !== 1'b0)
      $display("FAIL acq_wrong_sink: busy %b got_e %b want 1 0", busy, got_e);
    else n_pass++;
    e_sink = SINK;
    step();
    e_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || got_e !== 1'b1)
      $display("FAIL acq_grant_ack: busy %b got_e %b want 0 1", busy, got_e);
    else n_pass++;
    $display("txn acquire grant ack closed");
  endtask

  task automatic test_acquire_ntob();
    do_start(3'd7, 3'd0, 3'd6, 8'h56, 3'd0);
    od_valid = 1'b1; od_opcode = 3'd0; od_size = 3'd6; od_source = {2'b11, 8'h56};
    run_beats("acquire_ntob", 1, 3'd4, 3'd1, 8'h56, 1'b0);
    e_valid = 1'b1; e_sink = SINK;
    step();
    e_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || got_e !== 1'b1)
      $display("FAIL ntob_close: busy %b got_e %b want 0 1", busy, got_e);
    else n_pass++;
  endtask

  task automatic test_probe_saturate();
    probe_ack = 1'b1;
    step();
    probe_ack = 1'b0;
    n_checks++;
    if (probes_done !== 1'b1) $display("FAIL probe_saturate: probes_done %b want 1", probes_done);
    else n_pass++;
    $display("txn stray probe ack in idle");
  endtask

  task automatic test_reset_mid();
    int fires = 0;
    int cyc = 0;
    do_start(3'd4, 3'd0, 3'd6, 8'h12, 3'd0);
    od_valid = 1'b1; od_opcode = 3'd1; od_size = 3'd6; od_source = {2'b00, 8'h12};
    id_ready = 1'b1;
    while (fires < 3 && cyc < 20) begin
      #1;
      if (id_valid) fires++;
      step();
      cyc++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, id_valid, od_ready, d_last, got_e, probes_done} !== 6'b000011)
      $display("FAIL reset_mid: got %b want 000011 after %0d fires",
               {busy, id_valid, od_ready, d_last, got_e, probes_done}, fires);
    else n_pass++;
    step();
    od_valid = 1'b0; id_ready = 1'b0;
    reset = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_mid_idle: busy %b want 0", busy);
    else n_pass++;
    $display("txn reset mid burst after %0d beats", fires);
  endtask

  task automatic test_backpressure();
    do_start(3'd4, 3'd0, 3'd5, 8'h9A, 3'd0);
    od_valid = 1'b1; od_opcode = 3'd1; od_size = 3'd5; od_source = {2'b00, 8'h9A};
    run_beats("backpressure", 4, 3'd1, 3'd0, 8'h9A, 1'b1);
    step();
    n_checks++;
    if (d_last !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_done: d_last %b busy %b want 0 0", d_last, busy);
    else n_pass++;
  endtask

  task automatic test_err();
`ifdef TL_BCAST_RESP_CHECK_EN
    reset = 1'b0; step(); reset = 1'b1; step();
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err);
    else n_pass++;
    do_start(3'd4, 3'd0, 3'd3, 8'h12, 3'd0);
    od_valid = 1'b1; od_opcode = 3'd0; od_size = 3'd3; od_source = {2'b00, 8'h13};
    run_beats("src_mismatch", 1, 3'd0, 3'd0, 8'h13, 1'b0);
    repeat (2) step();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
    reset = 1'b0; #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_reset: got %b want 0", err);
    else n_pass++;
    step(); reset = 1'b1; step();
`else
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_tied: got %b want 0", err);
    else n_pass++;
    $display("txn err tied low");
`endif
  endtask

  initial begin
    test_reset();
    test_get();
    test_acquire_probes();
    test_acquire_ntob();
    test_probe_saturate();
    test_reset_mid();
    test_backpressure();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
